// File: rtl/icg_ctrl_multi.sv
// Multi-channel clock-gating controller: per-channel open/hold state machine,
// glitch-free latch-based gates and saturating activity counters.
module icg_ctrl_multi #(
  parameter int N_CH       = 4,
  parameter int HOLD       = 3,
  parameter int IDLE_LEVEL = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic                  test_en,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       clk_gated,
  output logic [N_CH-1:0]       gate_open,
  output logic [N_CH*CNT_W-1:0] act_cnt
);

  localparam int IDLE_W = 8;
  // Idle value at which the next de-asserted sample closes the channel.
  localparam logic [IDLE_W-1:0] CLOSE_AT = (HOLD == 0) ? IDLE_W'(0) : IDLE_W'(HOLD - 1);

  logic [N_CH-1:0]   r_open;
  logic [IDLE_W-1:0] r_idle [N_CH];
  logic [N_CH-1:0]   r_latch;
  logic [CNT_W-1:0]  r_cnt  [N_CH];
  logic [N_CH-1:0]   w_gate_en;
  logic              w_scan_bypass;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_open <= '0;
      for (int i = 0; i < N_CH; i++) r_idle[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (en[i]) begin
          r_idle[i] <= '0;
          r_open[i] <= 1'b1;
        end else if (r_open[i]) begin
          if (r_idle[i] == CLOSE_AT) begin
            r_open[i] <= 1'b0;
            r_idle[i] <= '0;
          end else begin
            r_idle[i] <= r_idle[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr) begin
          r_cnt[i] <= '0;
        end else if (r_latch[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_gate_en     = r_open | {N_CH{test_en}};
  // Scan mode must still see a free-running clock while the latches are held in reset.
  assign w_scan_bypass = test_en & ~rst_n;

  generate
    if (IDLE_LEVEL == 0) begin : g_and
      // NOTE: these are intentional level-sensitive latches; the enable may only
      // change while the gated clock is forced idle, so no pulse is ever cut short.
      always_latch begin
        if (!rst_n) begin
          r_latch <= '0;
        end else if (!clk_in) begin
          r_latch <= w_gate_en;
        end
      end
      assign clk_gated = {N_CH{clk_in}} & (r_latch | {N_CH{w_scan_bypass}});
    end else begin : g_or
      always_latch begin
        if (!rst_n) begin
          r_latch <= '0;
        end else if (clk_in) begin
          r_latch <= w_gate_en;
        end
      end
      assign clk_gated = {N_CH{clk_in}} | ~(r_latch | {N_CH{w_scan_bypass}});
    end
  endgenerate

  assign gate_open = r_open;

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign act_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

endmodule
